// File: rtl/stopwatch_core.sv
// Stopwatch core: tick edge detection, button debounce, start/stop/clear FSM and MM:SS.CC BCD count.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int DEB_SAMPLES = 4,
  parameter int MAX_MIN     = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_100hz,
  input  logic        clk_200hz,
  input  logic        btn_start,
  input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        btn_lap,
  output logic        lap_active,
`endif
  output logic [23:0] digits,
  output logic        running,
  output logic [1:0]  state,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int B_LAP   = 2;
  localparam int NB      = 3;
`else
  localparam int NB      = 2;
`endif
  localparam int CW = (DEB_SAMPLES < 2) ? 1 : $clog2(DEB_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);
  localparam logic [3:0]    MIN_T    = 4'(MAX_MIN / 10);
  localparam logic [3:0]    MIN_O    = 4'(MAX_MIN % 10);

  logic          p100_q, p200_q;
  logic          tick100, tick200;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] stable_q, stable_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] press;

  state_e        state_q, state_d;
  logic [3:0]    dig_q [6];
  logic [3:0]    dig_d [6];
  logic          ovf_q, ovf_d;
  logic          count_en, clr;
  logic [23:0]   live;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
  assign btn_raw = {btn_clear, btn_start};
`endif

  assign tick100 = clk_100hz & ~p100_q;
  assign tick200 = clk_200hz & ~p200_q;

  // NOTE: every variable written in always_comb is given a default first so no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick200) begin
        if (btn_raw[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = btn_raw[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Press pulse fires in the same cycle the stable state rises, so the FSM reacts on that edge.
  assign press = stable_d & ~stable_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (press[B_START]) state_d = S_RUN;
      S_RUN:   if (press[B_START]) state_d = S_PAUSE;
      S_PAUSE: begin
        if (press[B_CLEAR])      state_d = S_IDLE;
        else if (press[B_START]) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clr      = (state_q == S_PAUSE) && press[B_CLEAR];
  assign count_en = tick100 && (state_q == S_RUN);

  always_comb begin
    logic carry;
    for (int i = 0; i < 6; i++) dig_d[i] = dig_q[i];
    ovf_d = ovf_q;
    carry = count_en;
    if (clr) begin
      for (int i = 0; i < 6; i++) dig_d[i] = '0;
      ovf_d = 1'b0;
    end else begin
      // Sub-minute digits: cs_ones, cs_tens, s_ones roll at 9, s_tens rolls at 5.
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (dig_q[i] == ((i == 3) ? 4'd5 : 4'd9)) begin
            dig_d[i] = '0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      if (carry) begin
        if (dig_q[5] == MIN_T && dig_q[4] == MIN_O) begin
          dig_d[5] = '0;
          dig_d[4] = '0;
          ovf_d    = 1'b1;
        end else if (dig_q[4] == 4'd9) begin
          dig_d[4] = '0;
          dig_d[5] = dig_q[5] + 4'd1;
        end else begin
          dig_d[4] = dig_q[4] + 4'd1;
        end
      end
    end
  end

  assign live = {dig_q[5], dig_q[4], dig_q[3], dig_q[2], dig_q[1], dig_q[0]};

  // NOTE: sequential state uses non-blocking assignments only; the small counter arrays are reset
  // element by element because they are flops, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      p100_q   <= 1'b0;
      p200_q   <= 1'b0;
      stable_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      state_q  <= S_IDLE;
      for (int i = 0; i < 6; i++) dig_q[i] <= '0;
      ovf_q    <= 1'b0;
    end else begin
      p100_q   <= clk_100hz;
      p200_q   <= clk_200hz;
      stable_q <= stable_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      for (int i = 0; i < 6; i++) dig_q[i] <= dig_d[i];
      ovf_q    <= ovf_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_q, lap_d;
  logic [23:0] lap_dig_q, lap_dig_d;

  always_comb begin
    lap_d     = lap_q;
    lap_dig_d = lap_dig_q;
    if (clr) begin
      lap_d = 1'b0;
    end else if (state_q == S_RUN && press[B_LAP]) begin
      lap_d = ~lap_q;
      if (!lap_q) lap_dig_d = live;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q     <= 1'b0;
      lap_dig_q <= '0;
    end else begin
      lap_q     <= lap_d;
      lap_dig_q <= lap_dig_d;
    end
  end
`endif

  always_comb begin
    state   = state_q;
    running = (state_q == S_RUN);
    ovf     = ovf_q;
`ifdef STOPWATCH_LAP_EN
    lap_active = lap_q;
    digits     = lap_q ? lap_dig_q : live;
`else
    digits     = live;
`endif
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: model-driven scoreboard of digits/state/ovf after each stimulus step.
// Uses MAX_MIN=1 so the wrap boundary is reachable in a short run.
module tb_stopwatch_core;

  localparam int DEB    = 4;
  localparam int MAXM   = 1;
  localparam int PERIOD = (MAXM + 1) * 6000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c100 = 1'b0, c200 = 1'b0, bs = 1'b0, bc = 1'b0, bl = 1'b0;
  logic [23:0] digits;
  logic        running, ovf, lap_active;
  logic [1:0]  state;

  always #5 clk = ~clk;

  stopwatch_core #(.DEB_SAMPLES(DEB), .MAX_MIN(MAXM)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_100hz (c100),
    .clk_200hz (c200),
    .btn_start (bs),
    .btn_clear (bc),
`ifdef STOPWATCH_LAP_EN
    .btn_lap   (bl),
    .lap_active(lap_active),
`endif
    .digits    (digits),
    .running   (running),
    .state     (state),
    .ovf       (ovf)
  );

`ifndef STOPWATCH_LAP_EN
  assign lap_active = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [23:0] digits;
    logic [1:0]  state;
    logic        ovf;
    logic        lap;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_state, m_cs, m_ovf, m_lap, m_lap_cs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int mn, sc, cc;
    mn = cs / 6000;
    sc = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag    = tag;
    e.digits = to_bcd(m_lap != 0 ? m_lap_cs : m_cs);
    e.state  = 2'(m_state);
    e.ovf    = (m_ovf != 0);
    e.lap    = (m_lap != 0);
    sb_q.push_back(e);
  endtask

  // Called on the negative edge: pops every pending expectation and compares against the outputs.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".digits"}, 32'(digits), 32'(e.digits));
      check({e.tag, ".state"}, 32'(state), 32'(e.state));
      check({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
      check({e.tag, ".running"}, 32'(running), 32'(e.state == 2'(M_RUN)));
`ifdef STOPWATCH_LAP_EN
      check({e.tag, ".lap"}, 32'(lap_active), 32'(e.lap));
`endif
    end
  endtask

  task automatic expect_now(input string tag);
    push_exp(tag);
    drain();
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_cs = 0; m_ovf = 0; m_lap = 0; m_lap_cs = 0;
  endtask

  task automatic model_tick();
    if (m_state == M_RUN) begin
      m_cs = (m_cs + 1) % PERIOD;
      if (m_cs == 0) m_ovf = 1;
    end
  endtask

  task automatic model_press(input logic s, input logic c, input logic l);
    int old;
    old = m_state;
    if (old == M_RUN && l) begin
      if (m_lap != 0) m_lap = 0;
      else begin m_lap = 1; m_lap_cs = m_cs; end
    end
    case (old)
      M_IDLE:  if (s) m_state = M_RUN;
      M_RUN:   if (s) m_state = M_PAUSE;
      default: begin
        if (c) begin m_state = M_IDLE; m_cs = 0; m_ovf = 0; m_lap = 0; end
        else if (s) m_state = M_RUN;
      end
    endcase
  endtask

  task automatic tick200();
    @(negedge clk) c200 = 1'b1;
    @(negedge clk) c200 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) c100 = 1'b1;
      model_tick();
      @(negedge clk) c100 = 1'b0;
    end
  endtask

  // Holds the raw buttons for DEB samples (optionally with a coincident 100 Hz tick on the
  // accepting sample), checks the result, then releases them for DEB samples.
  task automatic press_btns(input string tag, input logic s, input logic c, input logic l,
                            input logic wt);
    bs = s; bc = c; bl = l;
    for (int i = 0; i < DEB; i++) begin
      @(negedge clk);
      c200 = 1'b1;
      if (wt && i == DEB - 1) begin
        c100 = 1'b1;
        model_tick();
      end
      @(negedge clk);
      c200 = 1'b0;
      c100 = 1'b0;
    end
    model_press(s, c, l);
    expect_now(tag);
    bs = 1'b0; bc = 1'b0; bl = 1'b0;
    repeat (DEB) tick200();
    expect_now({tag, "_rel"});
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset with inputs toggling; 100 Hz level left high across release.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c200 = ~c200; bs = ~bs; bc = ~bc; c100 = 1'b1;
    end
    @(negedge clk);
    c200 = 1'b0; bs = 1'b0; bc = 1'b0;
    rst = 1'b0;
    expect_now("reset");
    repeat (3) @(negedge clk);
    c100 = 1'b0;
    expect_now("held_100hz");

    // Three samples only: below the debounce threshold.
    bs = 1'b1;
    repeat (DEB - 1) tick200();
    bs = 1'b0;
    repeat (DEB) tick200();
    expect_now("short_pulse");

    // Button held with no 200 Hz ticks at all.
    bs = 1'b1;
    repeat (60) @(negedge clk);
    bs = 1'b0;
    expect_now("no_200hz");

    press_btns("start_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(250);
    expect_now("count_250");

    press_btns("clear_in_run", 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    expect_now("count_after_clear_run");

    ticks(PERIOD - 1 - m_cs);
    expect_now("max_value");
    ticks(1);
    expect_now("wrap");
    ticks(1);
    expect_now("after_wrap");

    press_btns("pause", 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    expect_now("paused_hold");

    press_btns("start_clear_pause", 1'b1, 1'b1, 1'b0, 1'b0);
    press_btns("clear_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    press_btns("start_clear_idle", 1'b1, 1'b1, 1'b0, 1'b0);

    ticks(3);
    press_btns("pause_with_tick", 1'b1, 1'b0, 1'b0, 1'b1);
    press_btns("resume_with_tick", 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(7);
    expect_now("resumed_count");

    // Reset mid-run with start held: debounce history must restart.
    bs = 1'b1;
    repeat (2) tick200();
    do_reset();
    expect_now("mid_reset");
    repeat (DEB - 1) tick200();
    expect_now("held_after_reset");
    tick200();
    model_press(1'b1, 1'b0, 1'b0);
    expect_now("press_after_reset");
    bs = 1'b0;
    repeat (DEB) tick200();

`ifdef STOPWATCH_LAP_EN
    ticks(105);
    expect_now("pre_lap");
    press_btns("lap_on", 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(50);
    expect_now("lap_frozen");
    press_btns("lap_off", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
